register_bank: RTL and testbench
================================

Name: register_bank

Overview:
- Architectural state of the 4-bit CPU: general registers A and B, output-port register, program counter (PC), and carry flag.
- Sits directly upstream of the 4:1 operand data selector. reg_a drives selector input c0 and reg_b drives c1. The input port (c2) and constant zero (c3) are wired at top level.
- Writes back the adder result chosen by the instruction decoder's one-hot load enables.
- Advances once per step_en pulse, so the slow/manual clock divider is the only thing that paces execution.

Parameters:
- WIDTH, 4, data width of A, B, OUT and of the adder result.
- PC_WIDTH, 4, program counter width (16-word ROM).
- PC_RESET, 0, PC value after reset.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- step_en  input  1  one-cycle-wide execution strobe; state changes only when high.
- alu_sum  input  WIDTH  adder result to write back.
- alu_carry  input  1  adder carry-out for this instruction.
- load_a  input  1  write alu_sum into A.
- load_b  input  1  write alu_sum into B.
- load_out  input  1  write alu_sum into OUT.
- load_pc  input  1  jump: write alu_sum[PC_WIDTH-1:0] into PC instead of incrementing.
- reg_a  output  WIDTH  register A (to selector c0).
- reg_b  output  WIDTH  register B (to selector c1).
- out_port  output  WIDTH  output-port register (LEDs).
- pc  output  PC_WIDTH  current ROM address.
- carry_flag  output  1  registered carry from the previous executed instruction (used by decoder for JNC).
- load_conflict  output  1  sticky: more than one load enable was seen high on a step.

Behaviour:
- Reset:
  - Synchronous, active-high, evaluated on rising clk.
  - Has priority over step_en and all load enables.
  - Clears reg_a, reg_b, out_port, carry_flag and load_conflict to 0, and sets pc to PC_RESET.
  - A reset mid-program discards that edge's load and increment entirely.
- step_en low: every register holds, including pc and carry_flag. Load enables are ignored.
- step_en high (one "instruction edge"):
  - A <= alu_sum if load_a. B <= alu_sum if load_b. OUT <= alu_sum if load_out.
  - PC <= alu_sum[PC_WIDTH-1:0] if load_pc, else PC <= PC + 1.
  - PC increments modulo 2^PC_WIDTH: 15 -> 0, no flag.
  - carry_flag <= alu_carry on every step, regardless of which load is active. This includes load_pc and the no-load case (NOP-like).
- Latency:
  - A write is visible on reg_* / out_port / pc the cycle after the step_en edge.
  - Outputs are pure register outputs, with no combinational path from inputs.
- Simultaneous loads:
  - The decoder guarantees one-hot, but if several enables are high, every asserted destination loads the same alu_sum.
  - load_conflict sets and stays 1 until reset. This includes load_pc with another load, where the PC jumps and the other register is also written.
- alu_sum wider than PC_WIDTH: only the low PC_WIDTH bits are used for a jump. alu_carry is not involved in the PC.
- step_en held high across consecutive cycles: each cycle is an independent instruction step.

Decomposition:
- Shared package cpu_pkg:
  - WIDTH and PC_WIDTH constants.
  - Selector code constants: SEL_A=2'b00, SEL_B=2'b01, SEL_IN=2'b10, SEL_ZERO=2'b11.
  - A load-enable vector typedef with bit order {load_pc, load_out, load_b, load_a}, so the decoder and this block share one definition.
- One natural sub-module: program_counter (step_en, load, load value, wrap-around increment, reset value), instantiated once.
- Registers A/B/OUT, carry_flag and load_conflict stay in register_bank.

Test Plan:
- Reset, then step_en pulse with alu_sum=4'h7, load_a=1 -> next cycle reg_a=7, reg_b=0, out_port=0, pc=1, carry_flag=alu_carry.
- load_b=1, alu_sum=4'hA, alu_carry=1, with step_en held low for 3 cycles -> nothing changes; then one step_en pulse -> reg_b=A, pc incremented by exactly 1, carry_flag=1.
- 16 step_en pulses with no loads from pc=0 -> pc wraps 15->0 and ends at 0; carry_flag tracks alu_carry each step.
- load_pc=1, alu_sum=4'h3 at pc=9 -> pc=3 next cycle (no increment); a following no-load step -> pc=4.
- load_a=1 and load_out=1 together, alu_sum=4'h5 -> reg_a=5, out_port=5, load_conflict=1 and stays 1 until reset.
- reset=1 on the same edge as step_en with load_a=1, alu_sum=4'hF -> reg_a=0, pc=PC_RESET, load_conflict=0, carry_flag=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: data/PC widths, operand selector
// codes and the load-enable vector used by the decoder and the register bank.
package cpu_pkg;

  localparam int WIDTH    = 4;
  localparam int PC_WIDTH = 4;

  // Operand data selector codes
  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  // Load-enable vector, bit order {load_pc, load_out, load_b, load_a}
  typedef logic [3:0] load_vec_t;

  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;
  localparam int LD_PC  = 3;

  // True when more than one destination is enabled at once
  function automatic logic multi_load(input load_vec_t v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      n = n + int'(v[i]);
    end
    return (n > 1);
  endfunction

endpackage

// File: rtl/register_bank_program_counter.sv
// Program counter: holds unless stepped; on a step either jumps to the
// supplied value or increments, wrapping silently at 2^PC_WIDTH.
module program_counter #(
  parameter int                  PC_WIDTH = 4,
  parameter logic [PC_WIDTH-1:0] PC_RESET = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                step_en,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_value,
  output logic [PC_WIDTH-1:0] pc
);

  logic [PC_WIDTH-1:0] pc_reg;
  logic [PC_WIDTH-1:0] pc_next;

  // Next address: jump target or natural wrap-around increment
  always_comb begin
    pc_next = pc_reg + PC_WIDTH'(1);
    if (load) begin
      pc_next = load_value;
    end
  end

  // Address register, advances only on an instruction edge
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= PC_RESET;
    end else if (step_en) begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/register_bank.sv
// Architectural state of the 4-bit CPU: A, B, OUT, PC and carry flag.
// All state advances only on step_en; outputs come straight from flops.
module register_bank #(
  parameter int                  WIDTH    = cpu_pkg::WIDTH,
  parameter int                  PC_WIDTH = cpu_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] PC_RESET = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                step_en,
  input  logic [WIDTH-1:0]    alu_sum,
  input  logic                alu_carry,
  input  logic                load_a,
  input  logic                load_b,
  input  logic                load_out,
  input  logic                load_pc,
  output logic [WIDTH-1:0]    reg_a,
  output logic [WIDTH-1:0]    reg_b,
  output logic [WIDTH-1:0]    out_port,
  output logic [PC_WIDTH-1:0] pc,
  output logic                carry_flag,
  output logic                load_conflict
);

  import cpu_pkg::*;

  load_vec_t        loads;
  logic [WIDTH-1:0] data_reg [3];
  logic             carry_reg;
  logic             conflict_reg;

  assign loads = {load_pc, load_out, load_b, load_a};

  // A, B and OUT share identical load behaviour, indexed by their enable bit
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_data
      // Data register: written with alu_sum when stepped and enabled
      always_ff @(posedge clk) begin
        if (reset) begin
          data_reg[gi] <= '0;
        end else if (step_en && loads[gi]) begin
          data_reg[gi] <= alu_sum;
        end
      end
    end
  endgenerate

  // Carry is captured on every step, whatever the destination
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_reg <= 1'b0;
    end else if (step_en) begin
      carry_reg <= alu_carry;
    end
  end

  // Sticky flag for decoder faults where several enables fire together
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_reg <= 1'b0;
    end else if (step_en && multi_load(loads)) begin
      conflict_reg <= 1'b1;
    end
  end

  program_counter #(
    .PC_WIDTH (PC_WIDTH),
    .PC_RESET (PC_RESET)
  ) u_pc (
    .clk        (clk),
    .reset      (reset),
    .step_en    (step_en),
    .load       (loads[LD_PC]),
    .load_value (alu_sum[PC_WIDTH-1:0]),
    .pc         (pc)
  );

  assign reg_a         = data_reg[LD_A];
  assign reg_b         = data_reg[LD_B];
  assign out_port      = data_reg[LD_OUT];
  assign carry_flag    = carry_reg;
  assign load_conflict = conflict_reg;

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed vector table, hand-written
// multi-cycle sequences, then randomized steps against a behavioural model.
module tb_register_bank;

  logic       clk;
  logic       reset;
  logic       step_en;
  logic [3:0] alu_sum;
  logic       alu_carry;
  logic       load_a;
  logic       load_b;
  logic       load_out;
  logic       load_pc;
  logic [3:0] reg_a;
  logic [3:0] reg_b;
  logic [3:0] out_port;
  logic [3:0] pc;
  logic       carry_flag;
  logic       load_conflict;

  int compared;
  int mismatched;

  register_bank #(
    .WIDTH    (4),
    .PC_WIDTH (4),
    .PC_RESET (4'd0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .step_en       (step_en),
    .alu_sum       (alu_sum),
    .alu_carry     (alu_carry),
    .load_a        (load_a),
    .load_b        (load_b),
    .load_out      (load_out),
    .load_pc       (load_pc),
    .reg_a         (reg_a),
    .reg_b         (reg_b),
    .out_port      (out_port),
    .pc            (pc),
    .carry_flag    (carry_flag),
    .load_conflict (load_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ld bit order {pc, out, b, a}
  typedef struct {
    bit       rst;
    bit       step;
    bit [3:0] sum;
    bit       cy;
    bit [3:0] ld;
    bit [3:0] ea;
    bit [3:0] eb;
    bit [3:0] eo;
    bit [3:0] epc;
    bit       ec;
    bit       ecf;
  } vec_t;

  vec_t vecs [12];

  // Behavioural model state
  int m_reg [3];
  int m_pc;
  int m_carry;
  int m_conf;

  task automatic cmp(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic check_all(input string tag, input int ea, input int eb, input int eo,
                           input int epc, input int ec, input int ecf);
    cmp({tag, ".reg_a"}, int'(reg_a), ea);
    cmp({tag, ".reg_b"}, int'(reg_b), eb);
    cmp({tag, ".out_port"}, int'(out_port), eo);
    cmp({tag, ".pc"}, int'(pc), epc);
    cmp({tag, ".carry_flag"}, int'(carry_flag), ec);
    cmp({tag, ".load_conflict"}, int'(load_conflict), ecf);
  endtask

  // Drive one cycle's inputs, let the edge happen, return #1 after it
  task automatic do_cycle(input bit rst, input bit step, input bit [3:0] sum,
                          input bit cy, input bit [3:0] ld);
    reset     = rst;
    step_en   = step;
    alu_sum   = sum;
    alu_carry = cy;
    load_a    = ld[0];
    load_b    = ld[1];
    load_out  = ld[2];
    load_pc   = ld[3];
    @(posedge clk);
    #1;
  endtask

  // Reference model: same rules as the register-transfer description
  task automatic model_step(input bit rst, input bit step, input bit [3:0] sum,
                            input bit cy, input bit [3:0] ld);
    int n;
    if (rst) begin
      for (int i = 0; i < 3; i++) m_reg[i] = 0;
      m_pc = 0; m_carry = 0; m_conf = 0;
    end else if (step) begin
      n = 0;
      for (int i = 0; i < 4; i++) if (ld[i]) n++;
      for (int i = 0; i < 3; i++) if (ld[i]) m_reg[i] = int'(sum);
      m_pc    = ld[3] ? (int'(sum) % 16) : ((m_pc + 1) % 16);
      m_carry = int'(cy);
      if (n > 1) m_conf = 1;
    end
  endtask

  initial begin
    bit       cy;
    bit       rst;
    bit       step;
    bit [3:0] sum;
    bit [3:0] ld;
    int       r;

    compared   = 0;
    mismatched = 0;

    //           rst step sum    cy  ld       ea     eb     eo     epc    ec  ecf
    vecs[0]  = '{0, 1, 4'h7, 0, 4'b0001, 4'h7, 4'h0, 4'h0, 4'd1, 0, 0};
    vecs[1]  = '{0, 0, 4'hA, 1, 4'b0010, 4'h7, 4'h0, 4'h0, 4'd1, 0, 0};
    vecs[2]  = '{0, 0, 4'hA, 1, 4'b0010, 4'h7, 4'h0, 4'h0, 4'd1, 0, 0};
    vecs[3]  = '{0, 0, 4'hA, 1, 4'b0010, 4'h7, 4'h0, 4'h0, 4'd1, 0, 0};
    vecs[4]  = '{0, 1, 4'hA, 1, 4'b0010, 4'h7, 4'hA, 4'h0, 4'd2, 1, 0};
    vecs[5]  = '{0, 1, 4'h3, 0, 4'b1000, 4'h7, 4'hA, 4'h0, 4'd3, 0, 0};
    vecs[6]  = '{0, 1, 4'h9, 1, 4'b0000, 4'h7, 4'hA, 4'h0, 4'd4, 1, 0};
    vecs[7]  = '{0, 1, 4'h5, 0, 4'b0101, 4'h5, 4'hA, 4'h5, 4'd5, 0, 1};
    vecs[8]  = '{0, 1, 4'h2, 1, 4'b0000, 4'h5, 4'hA, 4'h5, 4'd6, 1, 1};
    vecs[9]  = '{1, 1, 4'hF, 1, 4'b0001, 4'h0, 4'h0, 4'h0, 4'd0, 0, 0};
    vecs[10] = '{0, 1, 4'h9, 1, 4'b1010, 4'h0, 4'h9, 4'h0, 4'd9, 1, 1};
    vecs[11] = '{1, 0, 4'h6, 1, 4'b0111, 4'h0, 4'h0, 4'h0, 4'd0, 0, 0};

    // Power-on reset
    do_cycle(1, 0, 4'h0, 0, 4'b0000);
    do_cycle(1, 0, 4'h0, 0, 4'b0000);
    $display("reset: a=%0h b=%0h out=%0h pc=%0d c=%0b cf=%0b",
             reg_a, reg_b, out_port, pc, carry_flag, load_conflict);
    check_all("reset", 0, 0, 0, 0, 0, 0);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      do_cycle(vecs[i].rst, vecs[i].step, vecs[i].sum, vecs[i].cy, vecs[i].ld);
      $display("vec%0d: rst=%0b step=%0b sum=%0h cy=%0b ld=%b -> a=%0h b=%0h out=%0h pc=%0d c=%0b cf=%0b",
               i, vecs[i].rst, vecs[i].step, vecs[i].sum, vecs[i].cy, vecs[i].ld,
               reg_a, reg_b, out_port, pc, carry_flag, load_conflict);
      check_all($sformatf("vec%0d", i), int'(vecs[i].ea), int'(vecs[i].eb), int'(vecs[i].eo),
                int'(vecs[i].epc), int'(vecs[i].ec), int'(vecs[i].ecf));
    end

    // Sixteen no-load steps from pc=0: full wrap, carry follows input
    for (int i = 0; i < 16; i++) begin
      cy = 1'($urandom_range(0, 1));
      do_cycle(0, 1, 4'($urandom_range(0, 15)), cy, 4'b0000);
      $display("wrap%0d: pc=%0d c=%0b", i, pc, carry_flag);
      cmp($sformatf("wrap%0d.pc", i), int'(pc), (i + 1) % 16);
      cmp($sformatf("wrap%0d.carry_flag", i), int'(carry_flag), int'(cy));
    end

    // Jump to 9, jump from 9 to 3, then a plain step to 4
    do_cycle(0, 1, 4'h9, 0, 4'b1000);
    cmp("jmp9.pc", int'(pc), 9);
    do_cycle(0, 1, 4'h3, 1, 4'b1000);
    $display("jmp3: pc=%0d c=%0b", pc, carry_flag);
    cmp("jmp3.pc", int'(pc), 3);
    cmp("jmp3.carry_flag", int'(carry_flag), 1);
    do_cycle(0, 1, 4'h0, 0, 4'b0000);
    $display("nop: pc=%0d c=%0b", pc, carry_flag);
    cmp("nop.pc", int'(pc), 4);
    check_all("jmpseq", 0, 0, 0, 4, 0, 0);

    // Randomized steps against the model, starting from a clean reset
    do_cycle(1, 0, 4'h0, 0, 4'b0000);
    model_step(1, 0, 4'h0, 0, 4'b0000);
    for (int i = 0; i < 300; i++) begin
      rst  = ($urandom_range(0, 39) == 0);
      step = ($urandom_range(0, 3) != 0);
      sum  = 4'($urandom_range(0, 15));
      cy   = 1'($urandom_range(0, 1));
      r    = int'($urandom_range(0, 9));
      if (r == 0)      ld = 4'b0000;
      else if (r <= 4) ld = 4'(1 << (r - 1));
      else if (r == 5) ld = 4'($urandom_range(0, 15));
      else             ld = 4'(1 << $urandom_range(0, 2));
      do_cycle(rst, step, sum, cy, ld);
      model_step(rst, step, sum, cy, ld);
      $display("rnd%0d: rst=%0b step=%0b sum=%0h cy=%0b ld=%b -> a=%0h b=%0h out=%0h pc=%0d c=%0b cf=%0b",
               i, rst, step, sum, cy, ld, reg_a, reg_b, out_port, pc, carry_flag, load_conflict);
      check_all($sformatf("rnd%0d", i), m_reg[0], m_reg[1], m_reg[2], m_pc, m_carry, m_conf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
